// File: rtl/aes_stream_frontend.sv
// Byte-serial front/back end for the AES-128 decryptor core.
// Gathers a key and ciphertext blocks from byte streams, launches the core,
// then streams the captured plaintext out. The first byte of every 16-byte
// group lands in bits [127:120].
module aes_stream_frontend #(
    parameter int DONE_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   key_byte,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [7:0]   ct_byte,
    input  logic         ct_valid,
    output logic         ct_ready,
    output logic [127:0] core_key,
    output logic [127:0] core_ciphertext,
    output logic         core_start,
    input  logic         core_done,
    input  logic [127:0] core_plaintext,
    output logic [7:0]   pt_byte,
    output logic         pt_valid,
    input  logic         pt_ready,
    output logic         key_loaded,
    output logic         busy,
    output logic         err_timeout
);

    localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = (DONE_TIMEOUT > 0) ? TW'(DONE_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {FILL, LAUNCH, WAIT, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [3:0]    key_count, ct_count, pt_count;
    logic [TW-1:0] tmo_count;
    logic [127:0]  pt_sr;
    logic          key_acc, ct_acc, pt_acc, tmo_hit;

    assign key_acc = key_valid & key_ready;
    assign ct_acc  = ct_valid & ct_ready;
    assign pt_acc  = pt_valid & pt_ready;
    assign pt_byte = pt_sr[127:120];
    assign busy    = (state != FILL);
    // The last permitted WAIT cycle without done; a disabled timeout never hits.
    assign tmo_hit = (DONE_TIMEOUT != 0) && (tmo_count == TMO_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    // Next state and handshake outputs; key wins over ciphertext in FILL.
    always_comb begin
        state_nxt  = state;
        key_ready  = 1'b0;
        ct_ready   = 1'b0;
        core_start = 1'b0;
        pt_valid   = 1'b0;
        case (state)
            FILL: begin
                key_ready = (ct_count == 4'd0);
                ct_ready  = key_loaded && !(key_ready && key_valid);
                if (ct_valid && ct_ready && ct_count == 4'd15) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                core_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (core_done)    state_nxt = DRAIN;
                else if (tmo_hit) state_nxt = FILL;
            end
            DRAIN: begin
                pt_valid = 1'b1;
                if (pt_ready && pt_count == 4'd15) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    // Datapath: byte assembly, timeout counting, plaintext capture and drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_count       <= '0;
            ct_count        <= '0;
            pt_count        <= '0;
            tmo_count       <= '0;
            key_loaded      <= 1'b0;
            err_timeout     <= 1'b0;
            core_key        <= '0;
            core_ciphertext <= '0;
            pt_sr           <= '0;
        end else begin
            if (key_acc) begin
                core_key  <= {core_key[119:0], key_byte};
                key_count <= key_count + 4'd1;
                // A reload invalidates the old key from its first byte on.
                if (key_count == 4'd0)  key_loaded <= 1'b0;
                if (key_count == 4'd15) key_loaded <= 1'b1;
            end
            if (ct_acc) begin
                core_ciphertext <= {core_ciphertext[119:0], ct_byte};
                ct_count        <= ct_count + 4'd1;
            end
            case (state)
                LAUNCH: begin
                    ct_count  <= '0;
                    tmo_count <= '0;
                    pt_count  <= '0;
                end
                WAIT: begin
                    tmo_count <= tmo_count + TW'(1);
                    if (core_done)    pt_sr       <= core_plaintext;
                    else if (tmo_hit) err_timeout <= 1'b1;
                end
                DRAIN: begin
                    if (pt_acc) begin
                        pt_sr    <= {pt_sr[119:0], 8'h00};
                        pt_count <= pt_count + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_stream_frontend.sv
// Scoreboard bench for aes_stream_frontend. Instance a uses the default
// timeout, instance b a timeout of 8; the idle one is held in reset and the
// sel signal picks which instance's outputs are observed.
module tb_aes_stream_frontend;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, sel;
    logic [7:0]   key_byte, ct_byte;
    logic         key_valid, ct_valid, core_done, pt_ready;
    logic [127:0] core_plaintext;

    logic         a_key_ready, a_ct_ready, a_core_start, a_pt_valid, a_key_loaded, a_busy, a_err;
    logic         b_key_ready, b_ct_ready, b_core_start, b_pt_valid, b_key_loaded, b_busy, b_err;
    logic [127:0] a_core_key, a_core_ct, b_core_key, b_core_ct;
    logic [7:0]   a_pt_byte, b_pt_byte;

    logic         key_ready, ct_ready, core_start, pt_valid, key_loaded, busy, err_timeout;
    logic [127:0] core_key, core_ciphertext;
    logic [7:0]   pt_byte;

    aes_stream_frontend dut_a (
        .clk(clk), .rst(rst | sel),
        .key_byte(key_byte), .key_valid(key_valid), .key_ready(a_key_ready),
        .ct_byte(ct_byte), .ct_valid(ct_valid), .ct_ready(a_ct_ready),
        .core_key(a_core_key), .core_ciphertext(a_core_ct), .core_start(a_core_start),
        .core_done(core_done), .core_plaintext(core_plaintext),
        .pt_byte(a_pt_byte), .pt_valid(a_pt_valid), .pt_ready(pt_ready),
        .key_loaded(a_key_loaded), .busy(a_busy), .err_timeout(a_err)
    );

    aes_stream_frontend #(.DONE_TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst | !sel),
        .key_byte(key_byte), .key_valid(key_valid), .key_ready(b_key_ready),
        .ct_byte(ct_byte), .ct_valid(ct_valid), .ct_ready(b_ct_ready),
        .core_key(b_core_key), .core_ciphertext(b_core_ct), .core_start(b_core_start),
        .core_done(core_done), .core_plaintext(core_plaintext),
        .pt_byte(b_pt_byte), .pt_valid(b_pt_valid), .pt_ready(pt_ready),
        .key_loaded(b_key_loaded), .busy(b_busy), .err_timeout(b_err)
    );

    assign key_ready       = sel ? b_key_ready  : a_key_ready;
    assign ct_ready        = sel ? b_ct_ready   : a_ct_ready;
    assign core_start      = sel ? b_core_start : a_core_start;
    assign pt_valid        = sel ? b_pt_valid   : a_pt_valid;
    assign key_loaded      = sel ? b_key_loaded : a_key_loaded;
    assign busy            = sel ? b_busy       : a_busy;
    assign err_timeout     = sel ? b_err        : a_err;
    assign core_key        = sel ? b_core_key   : a_core_key;
    assign core_ciphertext = sel ? b_core_ct    : a_core_ct;
    assign pt_byte         = sel ? b_pt_byte    : a_pt_byte;

    int total = 0, bad = 0;
    int cyc = 0, n_start = 0, n_pt = 0, n_hold = 0;
    int done_cyc = 0, last_ct_cyc = 0, first_acc = 0, last_acc = 0, fall_cyc = 0, pt_idx = 0;
    int core_dly = 11, stall_k = 0;
    logic core_mute = 1'b0, stall_mode = 1'b0;
    logic hold_pending = 1'b0, prev_start = 1'b0, prev_valid = 1'b0, prev_busy = 1'b0;
    logic [7:0]   held = '0;
    logic [3:0]   stall_pat = 4'b1001;
    logic [127:0] exp_key = '0, exp_ct = '0, core_pt_next = '0;
    logic [7:0]   exp_q[$];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream ready: constant high, or the 1,0,0,1 stall pattern.
    initial begin
        pt_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_mode) begin
                pt_ready = stall_pat[stall_k];
                stall_k  = (stall_k + 1) % 4;
            end else begin
                pt_ready = 1'b1;
            end
        end
    end

    // Core model: done pulse core_dly cycles after start, unless muted.
    initial begin
        core_done = 1'b0;
        core_plaintext = '0;
        forever begin
            @(negedge clk);
            if (core_start && !core_mute) begin
                repeat (core_dly) @(posedge clk);
                #1;
                core_plaintext = core_pt_next;
                core_done = 1'b1;
                @(posedge clk); #1;
                core_done = 1'b0;
            end
        end
    end

    // Monitor: scoreboard pops, latency, pulse width, hold and stability checks.
    initial forever begin
        logic [7:0] eb;
        @(negedge clk);
        if (core_done) done_cyc = cyc;
        if (core_start) begin
            n_start++;
            chk("start_lat", cyc, last_ct_cyc + 1);
            chk("start_pulse", prev_start, 1'b0);
        end
        if (busy) chk("kc_hold", {core_key, core_ciphertext}, {exp_key, exp_ct});
        if (!busy) pt_idx = 0;
        if (!busy && prev_busy) fall_cyc = cyc;
        if (hold_pending && pt_valid) begin
            n_hold++;
            chk("pt_hold", pt_byte, held);
        end
        if (pt_valid && !prev_valid) chk("pt_lat", cyc, done_cyc + 1);
        if (pt_valid && pt_ready) begin
            if (exp_q.size() == 0) begin
                chk("pt_unexp", exp_q.size(), 1);
            end else begin
                eb = exp_q.pop_front();
                chk("pt_byte", pt_byte, eb);
            end
            if (pt_idx == 0) first_acc = cyc;
            last_acc = cyc;
            pt_idx++;
            n_pt++;
        end
        hold_pending = pt_valid && !pt_ready;
        held         = pt_byte;
        prev_start   = core_start;
        prev_valid   = pt_valid;
        prev_busy    = busy;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push_key(input logic [7:0] b);
        int n = 0;
        key_byte = b; key_valid = 1'b1;
        @(negedge clk);
        while (!key_ready && n < 100) begin @(negedge clk); n++; end
        chk("key_hs", key_ready, 1'b1);
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic push_ct(input logic [7:0] b);
        int n = 0;
        ct_byte = b; ct_valid = 1'b1;
        @(negedge clk);
        while (!ct_ready && n < 100) begin @(negedge clk); n++; end
        chk("ct_hs", ct_ready, 1'b1);
        last_ct_cyc = cyc;
        @(posedge clk); #1;
        ct_valid = 1'b0;
    endtask

    task automatic load_key(input logic [127:0] k, input int lo);
        for (int i = lo; i < 16; i++) push_key(k[127-8*i -: 8]);
    endtask

    task automatic send_ct(input logic [127:0] c, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) push_ct(c[127-8*i -: 8]);
    endtask

    task automatic start_block(input logic [127:0] c, input logic [127:0] p, input logic expect_out);
        exp_ct = c;
        core_pt_next = p;
        if (expect_out) for (int i = 0; i < 16; i++) exp_q.push_back(p[127-8*i -: 8]);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 400) begin @(negedge clk); n++; end
        chk("idle_busy", busy, 1'b0);
        chk("idle_q", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [127:0] k1, k2, ct1, pt1, ct2, pt2, ct3, pt3;
        logic any;
        int n0, s0, n;
        k1  = 128'h000102030405060708090a0b0c0d0e0f;
        ct1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        pt1 = 128'h00112233445566778899aabbccddeeff;
        k2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ct2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        pt2 = 128'h6bc1bee22e409f96e93d7e117393172a;
        ct3 = 128'hf5d3d58503b9699de785895a96fdbaaf;
        pt3 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        sel = 1'b0; rst = 1'b1;
        key_byte = '0; key_valid = 1'b0; ct_byte = '0; ct_valid = 1'b0;

        do_reset();
        chk("rst_flags", {key_loaded, err_timeout, busy, pt_valid, core_start, ct_ready}, '0);
        chk("rst_data", {core_key, core_ciphertext}, '0);
        chk("rst_pt_byte", pt_byte, 8'h00);
        chk("rst_key_ready", key_ready, 1'b1);

        // Ciphertext before any key is never accepted.
        ct_byte = 8'h69; ct_valid = 1'b1; any = 1'b0;
        repeat (20) begin @(posedge clk); #1; any = any | ct_ready; end
        ct_valid = 1'b0; #1;
        chk("nokey_ct_ready", any, 1'b0);
        chk("nokey_start", n_start, 0);
        chk("nokey_busy", busy, 1'b0);
        chk("nokey_key_ready", key_ready, 1'b1);

        // Known-answer block with a free-running sink.
        exp_key = k1;
        load_key(k1, 0);
        chk("key_loaded", key_loaded, 1'b1);
        n0 = n_pt; s0 = n_start;
        start_block(ct1, pt1, 1'b1);
        send_ct(ct1, 0, 15);
        wait_idle();
        chk("t1_starts", n_start - s0, 1);
        chk("t1_npt", n_pt - n0, 16);
        chk("t1_span", last_acc - first_acc, 15);
        chk("t1_busy_fall", fall_cyc, last_acc + 1);

        // Stalled drain.
        stall_mode = 1'b1;
        n0 = n_pt; n = n_hold;
        start_block(ct2, pt2, 1'b1);
        send_ct(ct2, 0, 15);
        wait_idle();
        stall_mode = 1'b0;
        chk("t3_npt", n_pt - n0, 16);
        chk("t3_stalled", n_hold > n, 1'b1);

        // Key priority over ciphertext, then key blocked mid-block.
        exp_key = k2;
        key_byte = k2[127:120]; key_valid = 1'b1; ct_byte = 8'h55; ct_valid = 1'b1; #1;
        chk("pri_key_ready", key_ready, 1'b1);
        chk("pri_ct_ready", ct_ready, 1'b0);
        @(posedge clk); #1;
        key_valid = 1'b0; ct_valid = 1'b0; #1;
        chk("reload_clr", key_loaded, 1'b0);
        load_key(k2, 1);
        chk("reload_set", key_loaded, 1'b1);
        n0 = n_pt;
        start_block(ct3, pt3, 1'b1);
        send_ct(ct3, 0, 2);
        key_byte = 8'hee; key_valid = 1'b1; #1;
        chk("blk_key_ready", key_ready, 1'b0);
        key_valid = 1'b0;
        send_ct(ct3, 3, 15);
        wait_idle();
        chk("t4_npt", n_pt - n0, 16);

        // Timeout on the DONE_TIMEOUT=8 instance.
        sel = 1'b1; core_dly = 4; core_mute = 1'b1;
        do_reset();
        exp_key = k1;
        load_key(k1, 0);
        n0 = n_pt;
        start_block(ct1, pt1, 1'b0);
        send_ct(ct1, 0, 15);
        n = 0;
        while (!core_start && n < 10) begin @(posedge clk); #1; n++; end
        chk("tmo_start", core_start, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        chk("tmo_pre_err", err_timeout, 1'b0);
        chk("tmo_pre_busy", busy, 1'b1);
        @(posedge clk); #1;
        chk("tmo_err", err_timeout, 1'b1);
        chk("tmo_busy", busy, 1'b0);
        chk("tmo_key_kept", key_loaded, 1'b1);
        chk("tmo_npt", n_pt - n0, 0);
        core_mute = 1'b0;
        start_block(ct2, pt2, 1'b1);
        send_ct(ct2, 0, 15);
        wait_idle();
        chk("tmo_next_npt", n_pt - n0, 16);
        chk("tmo_sticky", err_timeout, 1'b1);

        // Reset in the middle of the drain.
        n0 = n_pt;
        start_block(ct1, pt1, 1'b1);
        send_ct(ct1, 0, 15);
        n = 0;
        while (n_pt - n0 < 5 && n < 200) begin @(negedge clk); #1; n++; end
        chk("mid_npt", n_pt - n0, 5);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst", {pt_valid, key_loaded, busy, err_timeout}, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_quiet", n_pt - n0, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
